drum_hit_counter: RTL and testbench

DRUM_HIT_COUNTER -- requirements
Module: drum_hit_counter

---
 rtl/drum_pkg.sv | 86 ++++++++
 rtl/debounce_sync.sv | 68 ++++++
 rtl/drum_hit_counter.sv | 180 ++++++++++++++++++
 tb/tb_drum_hit_counter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// drum_pkg
//   Shared constants and helpers for the drum hit counter:
//     - cycle-count helpers that turn Hz / ms parameters into clock-cycle counts
//     - register width helper
//     - 7-segment encoding table (active-low {dp,g,f,e,d,c,b,a}, dp off)
//     - 8-entry RGB colour table, one bit per channel
package drum_pkg;

    // 10^n as a constant, used for BCD digit extraction and range checks.
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Bits needed to hold the values 0..max_val (never less than 1).
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Beep length in cycles. 64-bit intermediate: ms * Hz overflows 32 bits
    // at the default 500 ms / 50 MHz. Clamped to at least one cycle.
    function automatic int unsigned beep_cycles(input int unsigned clk_hz,
                                                input int unsigned ms);
        longint unsigned c;
        c = (64'(ms) * 64'(clk_hz)) / 64'd1000;
        return (c == 0) ? 1 : 32'(c);
    endfunction

    // Half period of the buzzer square wave in cycles (at least 1).
    function automatic int unsigned tone_half_cycles(input int unsigned clk_hz,
                                                     input int unsigned tone_hz);
        int unsigned c;
        c = clk_hz / (2 * tone_hz);
        return (c == 0) ? 1 : c;
    endfunction

    // Cycles each digit stays lit before the scan moves on (at least 1).
    function automatic int unsigned scan_cycles(input int unsigned clk_hz,
                                                input int unsigned refresh_hz,
                                                input int unsigned digits);
        int unsigned c;
        c = clk_hz / (refresh_hz * digits);
        return (c == 0) ? 1 : c;
    endfunction

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is always off.
    // Non-decimal codes show a blank digit.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // Colour table {r,g,b}: red, yellow, green, cyan, blue, white, off, magenta.
    function automatic logic [2:0] colour_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b100;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b010;
            3'd3:    rgb = 3'b011;
            3'd4:    rgb = 3'b001;
            3'd5:    rgb = 3'b111;
            3'd6:    rgb = 3'b000;
            default: rgb = 3'b101;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// debounce_sync
//   Two-flop synchroniser followed by a counter debouncer for one
//   asynchronous push input. The input counts as settled once the
//   synchronised sample has been unchanged for 2^(DEB_BITS-1) cycles.
//   rise pulses for one cycle when the debounced level goes 0 -> 1.
// Ports
//   CLK   : clock, rising edge
//   RESET : synchronous active-high reset
//   din   : raw asynchronous input
//   rise  : one-cycle pulse on each debounced rising edge
module debounce_sync #(
    parameter int unsigned DEB_BITS = 11
) (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic rise
);

    logic [1:0]          sync_reg;
    logic                sample_reg;
    logic [DEB_BITS-1:0] cnt_reg;
    logic                level_reg;
    logic                level_next;
    logic                primed_reg;
    logic                rise_reg;
    logic                cnt_msb;

    assign cnt_msb = cnt_reg[DEB_BITS-1];

    // The level only follows the sample while the counter says it is stable.
    always_comb begin
        level_next = level_reg;
        if (cnt_msb) begin
            level_next = sample_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_reg   <= '0;
            sample_reg <= 1'b0;
            cnt_reg    <= '0;
            level_reg  <= 1'b0;
            primed_reg <= 1'b0;
            rise_reg   <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[0], din};
            sample_reg <= sync_reg[1];
            // Any change restarts the stability count; saturate once the MSB is set.
            if (sync_reg[1] != sample_reg) begin
                cnt_reg <= '0;
            end else if (!cnt_msb) begin
                cnt_reg <= cnt_reg + DEB_BITS'(1);
            end
            level_reg <= level_next;
            // The first settled level after reset is adopted silently, so an
            // input already held high when reset lifts never produces an edge.
            if (cnt_msb) begin
                primed_reg <= 1'b1;
            end
            rise_reg <= primed_reg & level_next & ~level_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/drum_hit_counter.sv
// drum_hit_counter
//   Counts debounced piezo hits up or down (direction toggled by a button),
//   wrapping between 0 and COUNT_MAX. Each hit starts a beep on a passive
//   buzzer; the count is shown on multiplexed 7-segment digits with leading
//   zeros blanked and on three RGB LED bars coloured by COUNT mod 8.
// Ports
//   CLK     : clock, rising edge
//   RESET   : synchronous active-high reset
//   PIEZO   : async hit sensor, high = hit
//   UP_DOWN : async direction button, high = pressed
//   COUNT   : current count
//   SEG     : active-low segments {dp,g,f,e,d,c,b,a}
//   AN      : active-low digit enables, AN[0] = least-significant digit
//   LEDS_R/G/B : RGB LED bars, every bit of a channel equal
//   BUZZER  : square-wave buzzer drive, 0 when silent
module drum_hit_counter
    import drum_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DEB_BITS   = 11,
    parameter int unsigned COUNT_MAX  = 9,
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned REFRESH_HZ = 60,
    parameter int unsigned TONE_HZ    = 440,
    parameter int unsigned BEEP_MS    = 500
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic                               PIEZO,
    input  logic                               UP_DOWN,
    output logic [$clog2(COUNT_MAX+1)-1:0]     COUNT,
    output logic [7:0]                         SEG,
    output logic [NUM_DIGITS-1:0]              AN,
    output logic [7:0]                         LEDS_R,
    output logic [7:0]                         LEDS_G,
    output logic [7:0]                         LEDS_B,
    output logic                               BUZZER
);

    localparam int unsigned CW       = $clog2(COUNT_MAX + 1);
    localparam int unsigned BEEP_CYC = beep_cycles(CLK_HZ, BEEP_MS);
    localparam int unsigned BEEP_W   = width_for(BEEP_CYC);
    localparam int unsigned HALF_CYC = tone_half_cycles(CLK_HZ, TONE_HZ);
    localparam int unsigned TONE_W   = width_for(HALF_CYC - 1);
    localparam int unsigned SCAN_CYC = scan_cycles(CLK_HZ, REFRESH_HZ, NUM_DIGITS);
    localparam int unsigned SCAN_W   = width_for(SCAN_CYC - 1);
    localparam int unsigned IDX_W    = width_for(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("drum_hit_counter: NUM_DIGITS must be 1..8");
    end
    if (COUNT_MAX < 1 || COUNT_MAX > pow10(NUM_DIGITS) - 1) begin : g_bad_count
        $error("drum_hit_counter: COUNT_MAX must be 1..10^NUM_DIGITS-1");
    end

    // ---------------- input conditioning ----------------
    logic hit_rise;
    logic ud_rise;

    debounce_sync #(.DEB_BITS(DEB_BITS)) u_deb_piezo (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (PIEZO),
        .rise  (hit_rise)
    );

    debounce_sync #(.DEB_BITS(DEB_BITS)) u_deb_updown (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (UP_DOWN),
        .rise  (ud_rise)
    );

    // ---------------- counter ----------------
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          dir_reg;     // 0 = up

    // Uses dir_reg as registered, so a button edge in the same cycle as a
    // hit only affects later hits.
    always_comb begin
        count_next = count_reg;
        if (hit_rise) begin
            if (!dir_reg) begin
                count_next = (count_reg == CW'(COUNT_MAX)) ? '0 : count_reg + CW'(1);
            end else begin
                count_next = (count_reg == '0) ? CW'(COUNT_MAX) : count_reg - CW'(1);
            end
        end
    end

    // ---------------- beep and tone ----------------
    logic [BEEP_W-1:0] beep_cnt_reg;
    logic [TONE_W-1:0] tone_cnt_reg;
    logic              tone_reg;

    // ---------------- display scan ----------------
    logic [SCAN_W-1:0]     scan_div_reg;
    logic [IDX_W-1:0]      scan_idx_reg;
    logic [7:0]            seg_reg;
    logic [NUM_DIGITS-1:0] an_reg;
    logic [7:0]            seg_digit [NUM_DIGITS];
    logic [7:0]            seg_mux;

    genvar gi;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [3:0] bcd;
        logic       blank;
        assign bcd = 4'((32'(count_reg) / pow10(gi)) % 10);
        // Digit 0 always shows; higher digits blank while they would be a leading zero.
        if (gi == 0) begin : g_lsd
            assign blank = 1'b0;
        end else begin : g_upper
            assign blank = (32'(count_reg) < pow10(gi));
        end
        assign seg_digit[gi] = blank ? 8'hFF : seg_encode(bcd);
    end

    assign seg_mux = seg_digit[scan_idx_reg];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_reg    <= '0;
            dir_reg      <= 1'b0;
            beep_cnt_reg <= '0;
            tone_cnt_reg <= '0;
            tone_reg     <= 1'b0;
            scan_div_reg <= '0;
            scan_idx_reg <= '0;
            seg_reg      <= 8'hFF;
            an_reg       <= '1;
        end else begin
            count_reg <= count_next;
            if (ud_rise) begin
                dir_reg <= ~dir_reg;
            end

            // A new hit restarts the beep even if one is already sounding.
            if (hit_rise) begin
                beep_cnt_reg <= BEEP_W'(BEEP_CYC);
            end else if (beep_cnt_reg != '0) begin
                beep_cnt_reg <= beep_cnt_reg - BEEP_W'(1);
            end

            // Free-running tone; the beep only gates it onto the pin.
            if (tone_cnt_reg == TONE_W'(HALF_CYC - 1)) begin
                tone_cnt_reg <= '0;
                tone_reg     <= ~tone_reg;
            end else begin
                tone_cnt_reg <= tone_cnt_reg + TONE_W'(1);
            end

            if (scan_div_reg == SCAN_W'(SCAN_CYC - 1)) begin
                scan_div_reg <= '0;
                scan_idx_reg <= (scan_idx_reg == IDX_W'(NUM_DIGITS - 1)) ?
                                '0 : scan_idx_reg + IDX_W'(1);
            end else begin
                scan_div_reg <= scan_div_reg + SCAN_W'(1);
            end

            // SEG and AN come from the same scan index in the same register
            // stage, so the pattern never appears on the wrong digit.
            seg_reg <= seg_mux;
            an_reg  <= ~(NUM_DIGITS'(1) << scan_idx_reg);
        end
    end

    // ---------------- outputs ----------------
    logic [2:0] rgb;
    assign rgb = colour_rgb(3'(count_reg));

    assign COUNT  = count_reg;
    assign SEG    = seg_reg;
    assign AN     = an_reg;
    assign BUZZER = tone_reg & (beep_cnt_reg != '0);
    assign LEDS_R = {8{rgb[2]}};
    assign LEDS_G = {8{rgb[1]}};
    assign LEDS_B = {8{rgb[0]}};

endmodule

// File: tb/tb_drum_hit_counter.sv
// tb_drum_hit_counter
//   Directed bench for drum_hit_counter with small timing parameters:
//   debounce 8 cycles, beep 20 cycles, tone half period 5, scan step 10.
module tb_drum_hit_counter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       PIEZO;
    logic       UP_DOWN;
    logic [3:0] COUNT;
    logic [7:0] SEG;
    logic [1:0] AN;
    logic [7:0] LEDS_R;
    logic [7:0] LEDS_G;
    logic [7:0] LEDS_B;
    logic       BUZZER;

    int errors = 0;
    int checks = 0;

    drum_hit_counter #(
        .CLK_HZ     (1000),
        .DEB_BITS   (4),
        .COUNT_MAX  (9),
        .NUM_DIGITS (2),
        .REFRESH_HZ (50),
        .TONE_HZ    (100),
        .BEEP_MS    (20)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .PIEZO   (PIEZO),
        .UP_DOWN (UP_DOWN),
        .COUNT   (COUNT),
        .SEG     (SEG),
        .AN      (AN),
        .LEDS_R  (LEDS_R),
        .LEDS_G  (LEDS_G),
        .LEDS_B  (LEDS_B),
        .BUZZER  (BUZZER)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        int         hit_cyc;    // cycles PIEZO is held high
        int         ud_cyc;     // cycles UP_DOWN is held high (same start)
        logic [3:0] exp_count;  // COUNT once everything has settled
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("pass %s: 0x%0h", name, act);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        int len;
        len = (v.hit_cyc > v.ud_cyc) ? v.hit_cyc : v.ud_cyc;
        for (int c = 0; c < len; c++) begin
            PIEZO   = (c < v.hit_cyc);
            UP_DOWN = (c < v.ud_cyc);
            @(negedge CLK);
        end
        PIEZO   = 1'b0;
        UP_DOWN = 1'b0;
        repeat (30) @(negedge CLK);
        check(v.name, 32'(COUNT), 32'(v.exp_count));
    endtask

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    int       edges [$];
    logic     prev_b;
    int       n_ok;
    int       n_bad;
    int       bad_an;
    int       bad_seg;
    logic [1:0] prev_an;
    logic     found;
    vec_t     hv;

    initial begin
        vecs[0]  = '{"glitch_hit_no_step",    3,   0, 4'd0};
        vecs[1]  = '{"button_held_200",       0, 200, 4'd0};
        vecs[2]  = '{"hit_down_wraps_to_9",  20,   0, 4'd9};
        vecs[3]  = '{"button_back_to_up",     0,  20, 4'd9};
        vecs[4]  = '{"hit_up_wraps_to_0",    20,   0, 4'd0};
        vecs[5]  = '{"hit_up_1",             20,   0, 4'd1};
        vecs[6]  = '{"hit_up_2",             20,   0, 4'd2};
        vecs[7]  = '{"hit_up_3",             20,   0, 4'd3};
        vecs[8]  = '{"hit_and_button_same",  20,  20, 4'd4};
        vecs[9]  = '{"hit_after_toggle",     20,   0, 4'd3};
        vecs[10] = '{"button_glitch_ignored", 0,   3, 4'd3};
        vecs[11] = '{"hit_still_down",       20,   0, 4'd2};
        vecs[12] = '{"button_up_again",       0,  20, 4'd2};
        vecs[13] = '{"hit_up_3b",            20,   0, 4'd3};
        vecs[14] = '{"hit_up_4b",            20,   0, 4'd4};
        vecs[15] = '{"hit_up_5b",            20,   0, 4'd5};
        vecs[16] = '{"hit_up_6b",            20,   0, 4'd6};
        vecs[17] = '{"hit_up_7b",            20,   0, 4'd7};

        // ---- reset state ----
        RESET   = 1'b1;
        PIEZO   = 1'b0;
        UP_DOWN = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_count",  32'(COUNT),  32'd0);
        check("reset_buzzer", 32'(BUZZER), 32'd0);
        check("reset_an",     32'(AN),     32'h3);
        check("reset_seg",    32'(SEG),    32'hFF);
        check("reset_leds",   32'({LEDS_R, LEDS_G, LEDS_B}), 32'h00FF0000);
        RESET = 1'b0;
        repeat (20) @(negedge CLK);

        // ---- ten clean hits with buzzer tone check ----
        for (int p = 0; p < 10; p++) begin
            edges.delete();
            prev_b = BUZZER;
            for (int c = 0; c < 40; c++) begin
                PIEZO = (c < 20);
                @(negedge CLK);
                if (BUZZER !== prev_b) edges.push_back(c);
                prev_b = BUZZER;
            end
            check($sformatf("pulse%0d_count", p), 32'(COUNT), 32'((p + 1) % 10));
            check($sformatf("pulse%0d_buzzer_idle", p), 32'(BUZZER), 32'd0);
            // Only the beep gating can make a gap shorter than 5; none may be longer.
            n_ok  = 0;
            n_bad = 0;
            for (int i = 1; i < edges.size(); i++) begin
                if (edges[i] - edges[i-1] == 5) n_ok++;
                else if (edges[i] - edges[i-1] > 5) n_bad++;
            end
            checks++;
            if (n_ok < 2 || n_bad != 0) begin
                errors++;
                $display("FAIL pulse%0d_buzzer_tone: gaps of 5=%0d gaps over 5=%0d, expected >=2 and 0",
                         p, n_ok, n_bad);
            end else begin
                $display("pass pulse%0d_buzzer_tone: %0d edges", p, edges.size());
            end
        end

        // ---- table-driven vectors ----
        for (int i = 0; i < 18; i++) begin
            apply_vec(vecs[i]);
        end

        // ---- display scan at COUNT=7 ----
        bad_an  = 0;
        bad_seg = 0;
        edges.delete();
        prev_an = AN;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (AN !== prev_an) edges.push_back(c);
            prev_an = AN;
            if (AN == 2'b10) begin
                if (SEG !== 8'hF8) bad_seg++;
            end else if (AN == 2'b01) begin
                if (SEG !== 8'hFF) bad_seg++;
            end else begin
                bad_an++;
            end
        end
        check("scan_an_one_hot", 32'(bad_an), 32'd0);
        check("scan_seg_7_and_blank", 32'(bad_seg), 32'd0);
        n_ok  = 0;
        n_bad = 0;
        for (int i = 1; i < edges.size(); i++) begin
            if (edges[i] - edges[i-1] == 10) n_ok++;
            else n_bad++;
        end
        checks++;
        if (n_ok < 2 || n_bad != 0) begin
            errors++;
            $display("FAIL scan_period: gaps of 10=%0d other gaps=%0d, expected >=2 and 0", n_ok, n_bad);
        end else begin
            $display("pass scan_period: %0d digit changes", edges.size());
        end
        check("leds_entry7", 32'({LEDS_R, LEDS_G, LEDS_B}), 32'h00FF00FF);

        // ---- turn direction down, step to 6 ----
        hv = '{"button_down", 0, 20, 4'd7};
        apply_vec(hv);
        hv = '{"hit_down_to_6", 20, 0, 4'd6};
        apply_vec(hv);

        // ---- bouncing press: one step only, PIEZO then stays high ----
        for (int k = 0; k < 15; k++) begin
            PIEZO = (k % 2 == 0);
            repeat (2) @(negedge CLK);
        end
        check("bounce_no_step_yet", 32'(COUNT), 32'd6);
        repeat (15) @(negedge CLK);
        check("bounce_single_step", 32'(COUNT), 32'd5);

        // ---- reset in the middle of the beep, hit still held ----
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge CLK);
            if (BUZZER) found = 1'b1;
        end
        check("beep_sounding_before_reset", 32'(found), 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        check("midbeep_reset_buzzer", 32'(BUZZER), 32'd0);
        check("midbeep_reset_count",  32'(COUNT),  32'd0);
        check("midbeep_reset_an",     32'(AN),     32'h3);
        RESET = 1'b0;
        repeat (40) @(negedge CLK);
        check("held_hit_after_reset_no_step", 32'(COUNT), 32'd0);
        PIEZO = 1'b0;
        repeat (30) @(negedge CLK);
        hv = '{"fresh_hit_after_reset_up", 20, 0, 4'd1};
        apply_vec(hv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
